mem_port_arbiter: RTL and testbench

//  Shares one unified single-port memory between the instruction-fetch path and the data (load/store) path.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_streak.sv | 27 ++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encodings, requester IDs,
// streak/timeout widths and the data returned on an aborted transaction.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  localparam int STREAK_W = 3;
  localparam int TMO_W    = 16;
  localparam logic [31:0] ABORT_DATA = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// arb_streak_counter: 3-bit saturating count of data grants issued while a
// fetch request is waiting; at_max tells the arbiter to hand the next grant to fetch.
module arb_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [STREAK_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {STREAK_W{1'b1}})) begin
      count <= count + STREAK_W'(1);
    end
  end

  assign at_max = (count == STREAK_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store,
// data first with a fetch anti-starvation streak limit. Optional macro: ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_GNT,
  output logic        IF_VALID,
  output logic [31:0] IF_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_GNT,
  output logic        D_VALID,
  output logic [31:0] D_RDATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        ARB_ERR,
  output arb_state_e  DBG_STATE
);

  // Handshake: a requester holds REQ (and its fields) until GNT, which is
  // combinational and only asserted in IDLE; VALID is a one-cycle pulse after
  // MEM_ACK; MEM_REQ and MEM_* stay stable from the cycle after GNT until MEM_ACK.

  arb_state_e state, state_next;
  req_id_e    winner;
  logic       at_max;
  logic       abort;

  arb_streak_counter #(.MAX(MAX_D_STREAK)) u_streak (
    .clk    (CLK),
    .reset  (RESET),
    .inc    (D_GNT && IF_REQ),
    .clr    (IF_GNT || !IF_REQ),
    .at_max (at_max)
  );

  always_comb begin
    winner = (D_REQ && !(IF_REQ && at_max)) ? REQ_D : REQ_IF;
    IF_GNT = 1'b0;
    D_GNT  = 1'b0;
    if ((state == ARB_IDLE) && !RESET) begin
      D_GNT  = D_REQ && (winner == REQ_D);
      IF_GNT = IF_REQ && (winner == REQ_IF);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (D_GNT) state_next = ARB_BUSY_D;
        else if (IF_GNT) state_next = ARB_BUSY_IF;
      end
      ARB_BUSY_IF, ARB_BUSY_D: begin
        if (MEM_ACK || abort) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ARB_IDLE;
    else       state <= state_next;
  end

  assign DBG_STATE = state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      IF_VALID  <= 1'b0;
      D_VALID   <= 1'b0;
      IF_RDATA  <= '0;
      D_RDATA   <= '0;
    end else begin
      IF_VALID <= 1'b0;
      D_VALID  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (D_GNT) begin
            MEM_REQ   <= 1'b1;
            MEM_WE    <= D_WE;
            MEM_ADDR  <= D_ADDR;
            MEM_WDATA <= D_WDATA;
          end else if (IF_GNT) begin
            MEM_REQ   <= 1'b1;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= IF_ADDR;
            MEM_WDATA <= '0;
          end
        end
        ARB_BUSY_IF: begin
          if (MEM_ACK || abort) begin
            MEM_REQ  <= 1'b0;
            IF_VALID <= 1'b1;
            IF_RDATA <= MEM_ACK ? MEM_RDATA : ABORT_DATA;
          end
        end
        ARB_BUSY_D: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            D_VALID <= 1'b1;
            // stores complete without disturbing the last load result
            if (!MEM_WE) D_RDATA <= MEM_RDATA;
          end else if (abort) begin
            MEM_REQ <= 1'b0;
            D_VALID <= 1'b1;
            D_RDATA <= ABORT_DATA;
          end
        end
        default: MEM_REQ <= 1'b0;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // Counts completed BUSY cycles; held at zero in IDLE so every transaction starts fresh.
  always_ff @(posedge CLK) begin
    if (RESET || (state == ARB_IDLE)) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign abort = (state != ARB_IDLE) && !MEM_ACK &&
                 (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET)      ARB_ERR <= 1'b0;
    else if (abort) ARB_ERR <= 1'b1;
  end
`else
  assign abort   = 1'b0;
  assign ARB_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model with a behavioural memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAX_D = 4;
  localparam byte G_D = 8'h44;
  localparam byte G_I = 8'h49;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_REQ, D_REQ, D_WE, MEM_ACK;
  logic [31:0] IF_ADDR, D_ADDR, D_WDATA, MEM_RDATA;
  logic        IF_GNT, IF_VALID, D_GNT, D_VALID;
  logic        MEM_REQ, MEM_WE, ARB_ERR;
  logic [31:0] IF_RDATA, D_RDATA, MEM_ADDR, MEM_WDATA;
  arb_state_e  DBG_STATE;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] mem_model[logic [31:0]];
  byte         grant_q[$];

  mem_port_arbiter #(
    .MAX_D_STREAK(MAX_D)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .ARB_ERR(ARB_ERR), .DBG_STATE(DBG_STATE)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic zero_inputs();
    IF_REQ = 0; IF_ADDR = 0; D_REQ = 0; D_WE = 0; D_ADDR = 0; D_WDATA = 0;
    MEM_ACK = 0; MEM_RDATA = 0;
  endtask

  task automatic apply_reset();
    next_cycle();
    RESET = 1;
    zero_inputs();
    repeat (2) next_cycle();
    RESET = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    IF_REQ = 1; IF_ADDR = $urandom; D_REQ = 1; D_WE = 1; D_ADDR = $urandom; D_WDATA = $urandom;
    MEM_ACK = 1; MEM_RDATA = $urandom;
    repeat (2) next_cycle();
    sample();
    checks++; if (IF_GNT !== 1'b0) $display("FAIL reset_if_gnt: got %b want 0", IF_GNT); else passed++;
    checks++; if (D_GNT !== 1'b0) $display("FAIL reset_d_gnt: got %b want 0", D_GNT); else passed++;
    checks++; if ({IF_VALID, D_VALID} !== 2'b00) $display("FAIL reset_valids: got %b want 00", {IF_VALID, D_VALID}); else passed++;
    checks++; if (IF_RDATA !== 32'h0) $display("FAIL reset_if_rdata: got %h want 0", IF_RDATA); else passed++;
    checks++; if (D_RDATA !== 32'h0) $display("FAIL reset_d_rdata: got %h want 0", D_RDATA); else passed++;
    checks++; if ({MEM_REQ, MEM_WE} !== 2'b00) $display("FAIL reset_mem_req_we: got %b want 00", {MEM_REQ, MEM_WE}); else passed++;
    checks++; if (MEM_ADDR !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", MEM_ADDR); else passed++;
    checks++; if (MEM_WDATA !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", MEM_WDATA); else passed++;
    checks++; if (ARB_ERR !== 1'b0) $display("FAIL reset_arb_err: got %b want 0", ARB_ERR); else passed++;
    checks++; if (DBG_STATE !== ARB_IDLE) $display("FAIL reset_state: got %0d want %0d", DBG_STATE, ARB_IDLE); else passed++;
    next_cycle();
    zero_inputs();
    RESET = 0;
  endtask

  task automatic test_lone_fetch();
    apply_reset();
    next_cycle(); IF_REQ = 1; IF_ADDR = 32'h10;
    sample();
    checks++; if (IF_GNT !== 1'b1) $display("FAIL lone_if_gnt: got %b want 1", IF_GNT); else passed++;
    checks++; if (MEM_REQ !== 1'b0) $display("FAIL lone_mem_req_n: got %b want 0", MEM_REQ); else passed++;
    next_cycle(); IF_REQ = 0; IF_ADDR = 0; MEM_ACK = 1; MEM_RDATA = 32'h0050_0093;
    sample();
    checks++; if (MEM_REQ !== 1'b1) $display("FAIL lone_mem_req_n1: got %b want 1", MEM_REQ); else passed++;
    checks++; if (MEM_ADDR !== 32'h10) $display("FAIL lone_mem_addr: got %h want 00000010", MEM_ADDR); else passed++;
    checks++; if (MEM_WE !== 1'b0) $display("FAIL lone_mem_we: got %b want 0", MEM_WE); else passed++;
    checks++; if (IF_VALID !== 1'b0) $display("FAIL lone_valid_early: got %b want 0", IF_VALID); else passed++;
    next_cycle(); MEM_ACK = 0; MEM_RDATA = 32'hFFFF_FFFF;
    sample();
    checks++; if (IF_VALID !== 1'b1) $display("FAIL lone_if_valid: got %b want 1", IF_VALID); else passed++;
    checks++; if (IF_RDATA !== 32'h0050_0093) $display("FAIL lone_if_rdata: got %h want 00500093", IF_RDATA); else passed++;
    checks++; if (MEM_REQ !== 1'b0) $display("FAIL lone_mem_req_drop: got %b want 0", MEM_REQ); else passed++;
    next_cycle();
    sample();
    checks++; if (IF_VALID !== 1'b0) $display("FAIL lone_valid_pulse: got %b want 0", IF_VALID); else passed++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    next_cycle(); IF_REQ = 1; IF_ADDR = 32'h40; D_REQ = 1; D_WE = 0; D_ADDR = 32'h100;
    sample();
    checks++; if ({D_GNT, IF_GNT} !== 2'b10) $display("FAIL simul_first: got d,if=%b want 10", {D_GNT, IF_GNT}); else passed++;
    next_cycle(); D_REQ = 0; MEM_ACK = 1; MEM_RDATA = 32'h1111_1111;
    sample();
    checks++; if (MEM_ADDR !== 32'h100) $display("FAIL simul_d_addr: got %h want 00000100", MEM_ADDR); else passed++;
    checks++; if (IF_GNT !== 1'b0) $display("FAIL simul_busy_gnt: got %b want 0", IF_GNT); else passed++;
    next_cycle(); MEM_ACK = 0;
    sample();
    checks++; if (D_VALID !== 1'b1) $display("FAIL simul_d_valid: got %b want 1", D_VALID); else passed++;
    checks++; if (D_RDATA !== 32'h1111_1111) $display("FAIL simul_d_rdata: got %h want 11111111", D_RDATA); else passed++;
    checks++; if (IF_GNT !== 1'b1) $display("FAIL simul_if_gnt: got %b want 1", IF_GNT); else passed++;
    next_cycle(); IF_REQ = 0; MEM_ACK = 1; MEM_RDATA = 32'h2222_2222;
    sample();
    checks++; if (MEM_ADDR !== 32'h40) $display("FAIL simul_if_addr: got %h want 00000040", MEM_ADDR); else passed++;
    next_cycle(); MEM_ACK = 0;
    sample();
    checks++; if ({IF_VALID, D_VALID} !== 2'b10) $display("FAIL simul_if_valid: got if,d=%b want 10", {IF_VALID, D_VALID}); else passed++;
    checks++; if (IF_RDATA !== 32'h2222_2222) $display("FAIL simul_if_rdata: got %h want 22222222", IF_RDATA); else passed++;
  endtask

  task automatic test_store_delay();
    apply_reset();
    next_cycle(); D_REQ = 1; D_WE = 0; D_ADDR = 32'h30;
    next_cycle(); D_REQ = 0; MEM_ACK = 1; MEM_RDATA = 32'h1234_5678;
    next_cycle(); MEM_ACK = 0;
    sample();
    checks++; if (D_RDATA !== 32'h1234_5678) $display("FAIL store_preload: got %h want 12345678", D_RDATA); else passed++;
    next_cycle(); D_REQ = 1; D_WE = 1; D_ADDR = 32'h20; D_WDATA = 32'hCAFE_BABE;
    sample();
    checks++; if (D_GNT !== 1'b1) $display("FAIL store_gnt: got %b want 1", D_GNT); else passed++;
    for (int k = 0; k < 6; k++) begin
      next_cycle(); D_REQ = 0; D_WE = 0; D_ADDR = $urandom; D_WDATA = $urandom;
      MEM_ACK = (k == 5); MEM_RDATA = $urandom;
      sample();
      checks++; if ({MEM_REQ, MEM_WE} !== 2'b11) $display("FAIL store_req_we[%0d]: got %b want 11", k, {MEM_REQ, MEM_WE}); else passed++;
      checks++; if (MEM_ADDR !== 32'h20) $display("FAIL store_addr[%0d]: got %h want 00000020", k, MEM_ADDR); else passed++;
      checks++; if (MEM_WDATA !== 32'hCAFE_BABE) $display("FAIL store_wdata[%0d]: got %h want cafebabe", k, MEM_WDATA); else passed++;
      checks++; if (D_VALID !== 1'b0) $display("FAIL store_valid_early[%0d]: got %b want 0", k, D_VALID); else passed++;
    end
    next_cycle(); MEM_ACK = 0;
    sample();
    checks++; if (D_VALID !== 1'b1) $display("FAIL store_valid: got %b want 1", D_VALID); else passed++;
    checks++; if (D_RDATA !== 32'h1234_5678) $display("FAIL store_rdata_kept: got %h want 12345678", D_RDATA); else passed++;
    checks++; if (MEM_REQ !== 1'b0) $display("FAIL store_req_drop: got %b want 0", MEM_REQ); else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    next_cycle(); D_REQ = 1; D_WE = 0; D_ADDR = 32'h44;
    sample();
    checks++; if (D_GNT !== 1'b1) $display("FAIL rstmid_gnt: got %b want 1", D_GNT); else passed++;
    next_cycle(); D_REQ = 0;
    next_cycle(); RESET = 1;
    sample();
    checks++; if (DBG_STATE !== ARB_BUSY_D) $display("FAIL rstmid_busy: got %0d want %0d", DBG_STATE, ARB_BUSY_D); else passed++;
    next_cycle(); RESET = 0; MEM_ACK = 1; MEM_RDATA = 32'hDEAD_0001;
    sample();
    checks++; if (MEM_REQ !== 1'b0) $display("FAIL rstmid_req_drop: got %b want 0", MEM_REQ); else passed++;
    checks++; if (DBG_STATE !== ARB_IDLE) $display("FAIL rstmid_idle: got %0d want %0d", DBG_STATE, ARB_IDLE); else passed++;
    next_cycle(); MEM_ACK = 0;
    sample();
    checks++; if (D_VALID !== 1'b0) $display("FAIL rstmid_no_valid: got %b want 0", D_VALID); else passed++;
    checks++; if (D_RDATA !== 32'h0) $display("FAIL rstmid_rdata: got %h want 0", D_RDATA); else passed++;
    checks++; if ({DBG_STATE, MEM_REQ} !== {ARB_IDLE, 1'b0}) $display("FAIL rstmid_stay_idle: got %b want 000", {DBG_STATE, MEM_REQ}); else passed++;
  endtask

  // Reference model: a memory that answers each granted transaction after a random
  // wait, plus the arbitration rule (data first unless fetch has waited through
  // MAX_D data grants in a row).
  task automatic run_traffic(input int cycles, input int if_pct, input int d_pct, input int max_wait);
    bit busy = 0, if_gnt_prev = 0, d_gnt_prev = 0, ack_now;
    bit pend_if = 0, pend_d = 0, pend_d_load = 0;
    bit exp_if_g, exp_d_g, d_win;
    int wait_left = 0, d_run = 0;
    txn_t cur = '0;
    logic [31:0] rd, exp_v;
    logic [31:0] model_d_rdata = 32'h0;
    apply_reset();
    exp_if_q.delete(); exp_d_q.delete(); grant_q.delete();
    for (int c = 0; c < cycles + 24; c++) begin
      next_cycle();
      if (if_gnt_prev || !IF_REQ) begin
        IF_REQ = (c < cycles) && ($urandom_range(99) < if_pct);
        IF_ADDR = 32'h1000 + 32'($urandom_range(15)) * 4;
      end
      if (d_gnt_prev || !D_REQ) begin
        D_REQ = (c < cycles) && ($urandom_range(99) < d_pct);
        D_WE = $urandom_range(1);
        D_ADDR = 32'h1000 + 32'($urandom_range(15)) * 4;
        D_WDATA = $urandom;
      end
      ack_now = 0;
      if (busy) begin
        if (wait_left == 0) ack_now = 1;
        else wait_left--;
      end
      if (ack_now) begin
        MEM_ACK = 1;
        if (cur.we) begin
          mem_model[cur.addr] = cur.wdata;
          MEM_RDATA = $urandom;
        end else begin
          rd = mem_model.exists(cur.addr) ? mem_model[cur.addr] : (cur.addr ^ 32'h5A5A_0F0F);
          MEM_RDATA = rd;
          if (cur.is_d) exp_d_q.push_back(rd);
          else exp_if_q.push_back(rd);
        end
      end else begin
        MEM_ACK = !busy && ($urandom_range(3) == 0);
        MEM_RDATA = $urandom;
      end
      sample();
      d_win = D_REQ && !(IF_REQ && d_run == MAX_D);
      exp_d_g = !busy && d_win;
      exp_if_g = !busy && IF_REQ && !d_win;
      checks++; if (D_GNT !== exp_d_g) $display("FAIL traffic_d_gnt c%0d: got %b want %b", c, D_GNT, exp_d_g); else passed++;
      checks++; if (IF_GNT !== exp_if_g) $display("FAIL traffic_if_gnt c%0d: got %b want %b", c, IF_GNT, exp_if_g); else passed++;
      checks++; if (MEM_REQ !== busy) $display("FAIL traffic_mem_req c%0d: got %b want %b", c, MEM_REQ, busy); else passed++;
      checks++; if (ARB_ERR !== 1'b0) $display("FAIL traffic_arb_err c%0d: got %b want 0", c, ARB_ERR); else passed++;
      if (busy) begin
        checks++;
        if ({MEM_WE, MEM_ADDR} !== {cur.we, cur.addr} || (cur.we && MEM_WDATA !== cur.wdata))
          $display("FAIL traffic_mem_fields c%0d: got we=%b a=%h wd=%h want we=%b a=%h wd=%h",
                   c, MEM_WE, MEM_ADDR, MEM_WDATA, cur.we, cur.addr, cur.wdata);
        else passed++;
      end
      checks++; if (IF_VALID !== pend_if) $display("FAIL traffic_if_valid c%0d: got %b want %b", c, IF_VALID, pend_if); else passed++;
      if (pend_if) begin
        checks++;
        if (exp_if_q.size() == 0) $display("FAIL traffic_if_q c%0d: got valid want empty queue entry", c);
        else begin
          exp_v = exp_if_q.pop_front();
          if (IF_RDATA !== exp_v) $display("FAIL traffic_if_rdata c%0d: got %h want %h", c, IF_RDATA, exp_v);
          else passed++;
        end
      end
      checks++; if (D_VALID !== pend_d) $display("FAIL traffic_d_valid c%0d: got %b want %b", c, D_VALID, pend_d); else passed++;
      if (pend_d_load && exp_d_q.size() > 0) model_d_rdata = exp_d_q.pop_front();
      checks++; if (D_RDATA !== model_d_rdata) $display("FAIL traffic_d_rdata c%0d: got %h want %h", c, D_RDATA, model_d_rdata); else passed++;
      pend_if = ack_now && !cur.is_d;
      pend_d = ack_now && cur.is_d;
      pend_d_load = ack_now && cur.is_d && !cur.we;
      if (!IF_REQ || exp_if_g) d_run = 0;
      else if (exp_d_g && d_run < 7) d_run++;
      if (ack_now) busy = 0;
      if (exp_d_g) begin
        busy = 1; wait_left = $urandom_range(max_wait);
        cur.is_d = 1; cur.we = D_WE; cur.addr = D_ADDR; cur.wdata = D_WDATA;
        grant_q.push_back(G_D);
      end else if (exp_if_g) begin
        busy = 1; wait_left = $urandom_range(max_wait);
        cur.is_d = 0; cur.we = 0; cur.addr = IF_ADDR; cur.wdata = 32'h0;
        grant_q.push_back(G_I);
      end
      if_gnt_prev = exp_if_g;
      d_gnt_prev = exp_d_g;
    end
    checks++; if ({busy, pend_if, pend_d} !== 3'b000) $display("FAIL traffic_drain: got busy,pend=%b want 000", {busy, pend_if, pend_d}); else passed++;
    next_cycle();
    zero_inputs();
  endtask

  task automatic test_back_to_back();
    byte exp_order[10] = '{G_D, G_D, G_D, G_D, G_I, G_D, G_D, G_D, G_D, G_I};
    run_traffic(24, 100, 100, 0);
    checks++; if (grant_q.size() < 10) $display("FAIL b2b_grant_count: got %0d want >=10", grant_q.size()); else passed++;
    for (int i = 0; i < 10 && i < grant_q.size(); i++) begin
      checks++;
      if (grant_q[i] !== exp_order[i]) $display("FAIL b2b_order[%0d]: got %c want %c", i, grant_q[i], exp_order[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    run_traffic(400, 50, 50, 3);
    run_traffic(300, 90, 80, 2);
    run_traffic(300, 20, 95, 1);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    next_cycle(); IF_REQ = 1; IF_ADDR = 32'h80;
    sample();
    checks++; if (IF_GNT !== 1'b1) $display("FAIL tmo_gnt: got %b want 1", IF_GNT); else passed++;
    for (int k = 0; k < 8; k++) begin
      next_cycle(); IF_REQ = 0;
      sample();
      checks++; if ({MEM_REQ, IF_VALID, ARB_ERR} !== 3'b100) $display("FAIL tmo_wait[%0d]: got req,valid,err=%b want 100", k, {MEM_REQ, IF_VALID, ARB_ERR}); else passed++;
    end
    next_cycle();
    sample();
    checks++; if ({MEM_REQ, IF_VALID, ARB_ERR} !== 3'b011) $display("FAIL tmo_abort: got req,valid,err=%b want 011", {MEM_REQ, IF_VALID, ARB_ERR}); else passed++;
    checks++; if (IF_RDATA !== 32'h0) $display("FAIL tmo_rdata: got %h want 0", IF_RDATA); else passed++;
    repeat (3) next_cycle();
    sample();
    checks++; if (ARB_ERR !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", ARB_ERR); else passed++;
    apply_reset();
    sample();
    checks++; if (ARB_ERR !== 1'b0) $display("FAIL tmo_cleared: got %b want 0", ARB_ERR); else passed++;
  endtask
`endif

  initial begin
    zero_inputs();
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_store_delay();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
